// File: rtl/neuron_mac.sv
// neuron_mac: sequential multiply-accumulate stage feeding the leaky ReLU.
// Accepts NUM_INPUTS signed (data, weight) pairs per neuron, adds the bias
// (sampled on the first beat), rounds half-up, saturates to DATA_WIDTH and
// presents one result on a valid/ready output.
//
// Optional feature: define NEURON_MAC_CLEAR_EN to add the synchronous clr input.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   clr                       (NEURON_MAC_CLEAR_EN only) abort current neuron
//   in_valid/in_ready         input pair handshake
//   in_data, in_weight        signed operands
//   in_bias                   signed bias, used on the first beat only
//   out_valid/out_ready       result handshake
//   out_data, out_sat         rounded/saturated result and clip flag
//
// state   | meaning
// s_idle  | waiting for first pair of a neuron (bias sampled here)
// s_accum | accumulating remaining pairs
// s_round | one cycle: round and saturate the accumulator into out_data
// s_out   | result presented until out_ready
module neuron_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_INPUTS = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef NEURON_MAC_CLEAR_EN
  input  logic                         clr,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic signed [DATA_WIDTH-1:0] in_weight,
  input  logic signed [DATA_WIDTH-1:0] in_bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_sat
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam int RW    = ACC_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);
  localparam logic signed [RW-1:0] HALF =
    {{(RW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [RW-1:0] MAXV =
    {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV =
    {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {s_idle, s_accum, s_round, s_out} state_t;

  state_t                          state, state_nxt;
  logic signed [ACC_WIDTH-1:0]     acc;
  logic        [CNT_W-1:0]         count;
  logic signed [2*DATA_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]     prod_ext;
  logic signed [ACC_WIDTH-1:0]     bias_ext;
  logic signed [RW-1:0]            acc_rnd;
  logic signed [RW-1:0]            r;
  logic                            accept;
  logic                            clr_hit;

`ifdef NEURON_MAC_CLEAR_EN
  assign clr_hit = clr && (state != s_idle);
`else
  assign clr_hit = 1'b0;
`endif

  assign accept   = in_valid && in_ready;
  assign prod     = in_data * in_weight;
  assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){in_bias[DATA_WIDTH-1]}}, in_bias} <<< FRAC_BITS;
  // One extra bit so adding the rounding half can never wrap.
  assign acc_rnd  = {acc[ACC_WIDTH-1], acc} + HALF;
  assign r        = acc_rnd >>> FRAC_BITS;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= s_idle;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      s_idle:  if (accept) state_nxt = (NUM_INPUTS == 1) ? s_round : s_accum;
      s_accum: if (accept && count == LAST_BEAT) state_nxt = s_round;
      s_round: state_nxt = s_out;
      s_out:   if (out_ready) state_nxt = s_idle;
      default: state_nxt = s_idle;
    endcase
    if (clr_hit) state_nxt = s_idle;
  end

  // output decode; rst gating keeps both handshakes low in the reset cycle
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      case (state)
        s_idle, s_accum: in_ready  = !clr_hit;
        s_out:           out_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (clr_hit) begin
      acc   <= '0;
      count <= '0;
    end else begin
      case (state)
        s_idle: if (accept) begin
          acc   <= bias_ext + prod_ext;
          count <= CNT_W'(1);
        end
        s_accum: if (accept) begin
          acc   <= acc + prod_ext;
          count <= count + CNT_W'(1);
        end
        s_round: begin
          if (r > MAXV) begin
            out_data <= {1'b0, {(DATA_WIDTH-1){1'b1}}};
            out_sat  <= 1'b1;
          end else if (r < MINV) begin
            out_data <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
            out_sat  <= 1'b1;
          end else begin
            out_data <= r[DATA_WIDTH-1:0];
            out_sat  <= 1'b0;
          end
        end
        s_out: if (out_ready) begin
          acc   <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
